ram_sequencer: RTL and testbench

RAM_SEQUENCER -- requirements
Module: ram_sequencer

---
 rtl/ram_sequencer_pkg.sv | 30 +++
 rtl/addr_gen.sv | 46 ++++
 rtl/ram_sequencer.sv | 170 +++++++++++++++++
 tb/tb_ram_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ram_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_sequencer_pkg
// Purpose  : Shared definitions for the RAM sequencer: FSM state encoding,
//            layer count, default geometry and a counter-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package ram_sequencer_pkg;

  localparam int NUM_LAYERS  = 3;
  localparam int DEF_NEURONS = 4;
  localparam int DEF_INPUTS  = 4;
  localparam int DEF_ADDR_W  = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  // Width of a counter that spans 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : addr_gen
// Purpose  : Combinational address calculation for one layer pass.
// Ports    : i_layer  - latched layer index
//            i_n      - current neuron
//            i_i      - current input
//            o_w_addr - weight RAM address  (layer*N*I + n*I + i)
//            o_x_addr - activation address  (layer*I + i)
//            o_out_addr - result address    (layer*N + n)
// Revision : 1.0 - initial release
// ============================================================================
module addr_gen
  import ram_sequencer_pkg::*;
#(
  parameter int NEURONS = DEF_NEURONS,
  parameter int INPUTS  = DEF_INPUTS,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic [1:0]                 i_layer,
  input  logic [cnt_w(NEURONS)-1:0]  i_n,
  input  logic [cnt_w(INPUTS)-1:0]   i_i,
  output logic [ADDR_W-1:0]          o_w_addr,
  output logic [ADDR_W-1:0]          o_x_addr,
  output logic [ADDR_W-1:0]          o_out_addr
);

  localparam logic [ADDR_W-1:0] C_NI = ADDR_W'(NEURONS * INPUTS);
  localparam logic [ADDR_W-1:0] C_IN = ADDR_W'(INPUTS);
  localparam logic [ADDR_W-1:0] C_NE = ADDR_W'(NEURONS);

  logic [ADDR_W-1:0] w_layer;
  logic [ADDR_W-1:0] w_n;
  logic [ADDR_W-1:0] w_i;

  // Zero-extend everything to the address width before multiplying.
  assign w_layer = ADDR_W'(i_layer);
  assign w_n     = ADDR_W'(i_n);
  assign w_i     = ADDR_W'(i_i);

  assign o_w_addr   = w_layer * C_NI + w_n * C_IN + w_i;
  assign o_x_addr   = w_layer * C_IN + w_i;
  assign o_out_addr = w_layer * C_NE + w_n;

endmodule
`default_nettype wire

// File: rtl/ram_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ram_sequencer
// Purpose  : Steps one neural-network layer through the weight/activation
//            RAMs: per neuron it clears the accumulator, reads INPUTS
//            weight/activation pairs, waits one cycle for the last datum
//            and writes the result. Layer 3 is rejected with done+err.
// Ports    : clk, reset (sync, active-high)
//            start, layer      - begin a pass on the given layer
//            w_addr, x_addr    - RAM read addresses, rd_en read strobe
//            mac_clear, mac_en - accumulator control
//            out_we, out_addr  - result write
//            done, err         - end-of-pass pulse and bad-layer flag
// Revision : 1.0 - initial release
// ============================================================================
module ram_sequencer
  import ram_sequencer_pkg::*;
#(
  parameter int NEURONS = DEF_NEURONS,
  parameter int INPUTS  = DEF_INPUTS,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        layer,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] x_addr,
  output logic              rd_en,
  output logic              mac_clear,
  output logic              mac_en,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic              done,
  output logic              err
);

  localparam int NW = cnt_w(NEURONS);
  localparam int IW = cnt_w(INPUTS);
  localparam logic [NW-1:0] C_N_LAST = NW'(NEURONS - 1);
  localparam logic [IW-1:0] C_I_LAST = IW'(INPUTS - 1);

  state_t            r_state;
  logic [1:0]        r_layer_q;
  logic [NW-1:0]     r_n;
  logic [IW-1:0]     r_i;
  logic              r_err_q;

  logic              r_rd_en;
  logic              r_mac_clear;
  logic              r_mac_en;
  logic              r_out_we;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_w_addr;
  logic [ADDR_W-1:0] r_x_addr;
  logic [ADDR_W-1:0] r_out_addr;

  logic [ADDR_W-1:0] w_w_addr;
  logic [ADDR_W-1:0] w_x_addr;
  logic [ADDR_W-1:0] w_out_addr;

  addr_gen #(
    .NEURONS (NEURONS),
    .INPUTS  (INPUTS),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .i_layer    (r_layer_q),
    .i_n        (r_n),
    .i_i        (r_i),
    .o_w_addr   (w_w_addr),
    .o_x_addr   (w_x_addr),
    .o_out_addr (w_out_addr)
  );

  // Outputs are registered images of the current state, so each strobe
  // appears one cycle after the state that owns it; mac_en trails rd_en by
  // one more cycle to line up with the RAM read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_layer_q   <= 2'd0;
      r_n         <= '0;
      r_i         <= '0;
      r_err_q     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_mac_clear <= 1'b0;
      r_mac_en    <= 1'b0;
      r_out_we    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_w_addr    <= '0;
      r_x_addr    <= '0;
      r_out_addr  <= '0;
    end else begin
      r_rd_en     <= 1'b0;
      r_mac_clear <= 1'b0;
      r_out_we    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mac_en    <= r_rd_en;
      r_w_addr    <= w_w_addr;
      r_x_addr    <= w_x_addr;
      r_out_addr  <= w_out_addr;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_layer_q <= layer;
            r_n       <= '0;
            r_i       <= '0;
            if (layer >= 2'(NUM_LAYERS)) begin
              // Illegal layer: report immediately without touching RAM.
              r_err_q <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_state <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          r_mac_clear <= 1'b1;
          r_i         <= '0;
          r_state     <= S_READ;
        end
        S_READ: begin
          r_rd_en <= 1'b1;
          if (r_i == C_I_LAST) begin
            r_state <= S_DRAIN;
          end else begin
            r_i <= r_i + 1'b1;
          end
        end
        S_DRAIN: begin
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_out_we <= 1'b1;
          if (r_n == C_N_LAST) begin
            r_state <= S_FIN;
          end else begin
            r_n     <= r_n + 1'b1;
            r_state <= S_CLEAR;
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_err   <= r_err_q;
          r_err_q <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_addr    = r_w_addr;
  assign x_addr    = r_x_addr;
  assign rd_en     = r_rd_en;
  assign mac_clear = r_mac_clear;
  assign mac_en    = r_mac_en;
  assign out_we    = r_out_we;
  assign out_addr  = r_out_addr;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_sequencer
// Purpose  : Directed self-checking bench for ram_sequencer (default
//            geometry: 4 neurons x 4 inputs, 6-bit addresses).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] layer = 2'd0;
  logic [5:0] w_addr;
  logic [5:0] x_addr;
  logic       rd_en;
  logic       mac_clear;
  logic       mac_en;
  logic       out_we;
  logic [5:0] out_addr;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  ram_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .layer     (layer),
    .w_addr    (w_addr),
    .x_addr    (x_addr),
    .rd_en     (rd_en),
    .mac_clear (mac_clear),
    .mac_en    (mac_en),
    .out_we    (out_we),
    .out_addr  (out_addr),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle invariants: mac_en follows last cycle's rd_en, strobes exclusive.
  logic mon_en = 1'b0;
  logic prev_rd = 1'b0;
  logic rst_at_edge = 1'b1;
  always @(posedge clk) rst_at_edge <= reset;
  always @(negedge clk) begin
    if (mon_en && !rst_at_edge) begin
      check("mac_en_pipe", int'(mac_en), int'(prev_rd));
      check("strobe_excl",
            int'((int'(rd_en) + int'(mac_clear) + int'(out_we) + int'(done)) <= 1), 1);
    end
    prev_rd = rd_en;
  end

  // Full pass on layer L. Cycle k = k edges after the start edge.
  // Neuron nn occupies cycles 7*nn+1..7*nn+7: clear, 4 reads, drain, write.
  // mode 1 pulses start and toggles layer mid-pass.
  task automatic run_pass(input int L, input int mode);
    int kk, nn, p;
    start = 1'b1;
    layer = 2'(L);
    tick();                      // start edge
    start = 1'b0;
    for (int k = 1; k <= 29; k++) begin
      if (mode == 1) begin
        layer = 2'(k);
        start = (k == 10 || k == 20);
      end
      tick();
      kk = k - 1;
      nn = kk / 7;
      p  = kk % 7;
      if (k == 29) begin
        check("done_end", int'(done), 1);
        check("err_end", int'(err), 0);
      end else begin
        check("done_mid", int'(done), 0);
        check("mac_clear", int'(mac_clear), int'(p == 0));
        check("rd_en", int'(rd_en), int'(p >= 1 && p <= 4));
        check("out_we", int'(out_we), int'(p == 6));
        if (p >= 1 && p <= 4) begin
          check("w_addr", int'(w_addr), L * 16 + nn * 4 + (p - 1));
          check("x_addr", int'(x_addr), L * 4 + (p - 1));
        end
        if (p == 6) check("out_addr", int'(out_addr), L * 4 + nn);
      end
    end
    start = 1'b0;
    layer = 2'd0;
  endtask

  initial begin
    int first_done, second_done, cyc;

    // Reset: every output low, addresses included.
    tick();
    tick();
    reset = 1'b0;
    check("rst_w_addr", int'(w_addr), 0);
    check("rst_x_addr", int'(x_addr), 0);
    check("rst_out_addr", int'(out_addr), 0);
    check("rst_ctrl", int'({rd_en, mac_clear, mac_en, out_we, done, err}), 0);
    mon_en = 1'b1;
    tick();

    run_pass(0, 0);
    tick();
    run_pass(2, 0);
    tick();
    run_pass(1, 0);
    tick();

    // Illegal layer: done+err in the FIN cycle right after the start edge.
    start = 1'b1;
    layer = 2'd3;
    tick();
    start = 1'b0;
    layer = 2'd0;
    tick();
    check("l3_done", int'(done), 1);
    check("l3_err", int'(err), 1);
    check("l3_rd", int'(rd_en), 0);
    for (int k = 2; k <= 6; k++) begin
      tick();
      check("l3_quiet", int'({done, err, rd_en, out_we, mac_clear}), 0);
    end

    // Reset during neuron 2 READ (state READ for neuron 2 spans edges 15..18).
    start = 1'b1;
    layer = 2'd1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 16; k++) tick();
    check("pre_rst_rd", int'(rd_en), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_addr", int'({w_addr, x_addr, out_addr}), 0);
    check("abort_ctrl", int'({rd_en, mac_clear, mac_en, out_we, done, err}), 0);
    for (int k = 0; k < 35; k++) begin
      tick();
      check("abort_idle", int'({done, rd_en, mac_clear, out_we}), 0);
    end
    run_pass(1, 0);
    tick();

    // Mid-pass start pulses and layer toggling are ignored.
    run_pass(2, 1);
    tick();

    // start held high: back-to-back passes, done pulses 30 cycles apart.
    first_done = -1;
    second_done = -1;
    start = 1'b1;
    layer = 2'd1;
    tick();                      // start edge = cycle 0
    cyc = 0;
    while (second_done < 0 && cyc < 100) begin
      tick();
      cyc++;
      if (done) begin
        if (first_done < 0) first_done = cyc;
        else begin
          second_done = cyc;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("held_first_done", first_done, 29);
    check("held_gap", second_done - first_done, 30);
    for (int k = 0; k < 32; k++) tick();

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
